// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared constants and display mode type for the seven-segment path
package seven_seg_pkg;

  localparam int         NUM_DIGITS = 8;
  localparam logic [7:0] BLANK_ALL  = 8'hFF;
  localparam logic [7:0] POINTS_OFF = 8'hFF;

  typedef enum logic {
    MODE_HIST  = 1'b0,
    MODE_COUNT = 1'b1
  } disp_mode_e;

endpackage

// File: rtl/pulse_stretch.sv
// rtl/pulse_stretch.sv - stretches a one-cycle trigger into a CYCLES-long activity flag
module pulse_stretch #(
  parameter int CYCLES = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trig,
  input  logic clr,
  output logic active
);

  localparam int W = $clog2(CYCLES + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (trig) begin
      cnt_d = W'(CYCLES - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // The trigger cycle itself counts, so the flag spans the strobe plus CYCLES-1 more.
  assign active = !clr && (trig || (cnt_q != '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_byte_display.sv
// rtl/uart_byte_display.sv - formats received UART bytes into seven-segment value/point/mask
module uart_byte_display
  import seven_seg_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int ACT_MS   = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_error,
  input  logic        mode,
  input  logic        clear,
  output logic [31:0] value,
  output logic [7:0]  point,
  output logic [7:0]  mask_n
);

  localparam int ACT_CYCLES = CLK_FREQ / 1000 * ACT_MS;

  logic [31:0] hist_q, hist_d;
  logic [2:0]  fill_q, fill_d;
  logic [31:0] byte_cnt_q, byte_cnt_d;
  logic        err_q, err_d;
  logic [31:0] value_q, value_d;
  logic [7:0]  point_q, point_d;
  logic [7:0]  mask_n_q, mask_n_d;
  logic        act_active;
  disp_mode_e  mode_e;

  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [31:0] v);
    logic zero_above;
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above && (v[4*i +: 4] == 4'h0);
      lz_mask[i] = zero_above;
    end
  endfunction

  // Byte k (0 = newest) owns digits 2k+1:2k and stays dark until it has arrived.
  function automatic logic [NUM_DIGITS-1:0] fill_mask(input logic [2:0] f);
    fill_mask = '0;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) >= f) fill_mask[2*k +: 2] = 2'b11;
    end
  endfunction

  pulse_stretch #(
    .CYCLES (ACT_CYCLES)
  ) u_act (
    .clk    (clk),
    .rst_n  (rst_n),
    .trig   (rx_valid),
    .clr    (clear),
    .active (act_active)
  );

  assign mode_e = disp_mode_e'(mode);

  always_comb begin
    hist_d     = hist_q;
    fill_d     = fill_q;
    byte_cnt_d = byte_cnt_q;
    err_d      = err_q;
    if (clear) begin
      hist_d     = '0;
      fill_d     = '0;
      byte_cnt_d = '0;
      err_d      = 1'b0;
    end else if (rx_valid && rx_error) begin
      err_d = 1'b1;
    end else if (rx_valid) begin
      hist_d = {hist_q[23:0], rx_data};
      if (fill_q != 3'd4) fill_d = fill_q + 3'd1;
      if (byte_cnt_q != 32'hFFFF_FFFF) byte_cnt_d = byte_cnt_q + 32'd1;
    end
  end

  // Outputs are built from next state so a strobe shows up one cycle later.
  always_comb begin
    value_d  = hist_d;
    mask_n_d = fill_mask(fill_d);
    if (mode_e == MODE_COUNT) begin
      value_d  = byte_cnt_d;
      mask_n_d = lz_mask(byte_cnt_d);
    end
    point_d = {~err_d, 6'h3F, ~act_active};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q     <= '0;
      fill_q     <= '0;
      byte_cnt_q <= '0;
      err_q      <= 1'b0;
      value_q    <= '0;
      point_q    <= POINTS_OFF;
      mask_n_q   <= BLANK_ALL;
    end else begin
      hist_q     <= hist_d;
      fill_q     <= fill_d;
      byte_cnt_q <= byte_cnt_d;
      err_q      <= err_d;
      value_q    <= value_d;
      point_q    <= point_d;
      mask_n_q   <= mask_n_d;
    end
  end

  assign value  = value_q;
  assign point  = point_q;
  assign mask_n = mask_n_q;

endmodule

// File: tb/tb_uart_byte_display.sv
// tb/tb_uart_byte_display.sv - scoreboard bench for uart_byte_display
module tb_uart_byte_display;

  typedef struct packed {
    logic [31:0] value;
    logic [7:0]  point;
    logic [7:0]  mask_n;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_error = 1'b0;
  logic        mode = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] value;
  logic [7:0]  point;
  logic [7:0]  mask_n;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];

  bit [7:0] m_hist[$];
  longint   m_cnt;
  bit       m_err;
  int       m_last;
  int       cyc;

  uart_byte_display #(
    .CLK_FREQ (10_000),
    .ACT_MS   (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_error (rx_error),
    .mode     (mode),
    .clear    (clear),
    .value    (value),
    .point    (point),
    .mask_n   (mask_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    m_cnt  = 0;
    m_err  = 1'b0;
    m_last = -1000;
  endtask

  function automatic exp_t model_out(input bit m);
    exp_t e;
    int   nd;
    e.value = 32'h0;
    if (m) begin
      e.value = m_cnt[31:0];
      nd = 1;
      while (nd < 8 && (m_cnt >> (4 * nd)) != 0) nd++;
      e.mask_n = 8'(8'hFF << nd);
    end else begin
      foreach (m_hist[i]) e.value = (e.value << 8) | 32'(m_hist[i]);
      e.mask_n = 8'(8'hFF << (2 * m_hist.size()));
    end
    e.point    = 8'h7E;
    e.point[7] = ~m_err;
    e.point[0] = !((cyc + 1 - m_last) <= 10);
    return e;
  endfunction

  task automatic step(input bit v, input bit [7:0] d, input bit e, input bit m, input bit c);
    @(negedge clk);
    rx_valid = v;
    rx_data  = d;
    rx_error = e;
    mode     = m;
    clear    = c;
    if (c) begin
      model_reset();
    end else if (v) begin
      m_last = cyc;
      if (e) begin
        m_err = 1'b1;
      end else begin
        m_hist.push_back(d);
        if (m_hist.size() > 4) void'(m_hist.pop_front());
        if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
      end
    end
    exp_q.push_back(model_out(m));
    cyc++;
  endtask

  task automatic idle(input int n, input bit m);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, m, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("value", value, e.value);
        check("point", 32'(point), 32'(e.point));
        check("mask_n", 32'(mask_n), 32'(e.mask_n));
      end
    end
  end

  initial begin : stim
    int wait_cnt;
    model_reset();
    cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_value", value, 32'h0);
    check("reset_point", 32'(point), 32'hFF);
    check("reset_mask", 32'(mask_n), 32'hFF);
    @(negedge clk);
    rst_n = 1'b1;

    idle(2, 1'b0);
    step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h43, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h45, 1'b0, 1'b0, 1'b0);
    idle(14, 1'b0);

    // single byte then a retrigger five cycles later
    step(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
    idle(13, 1'b0);
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    idle(4, 1'b0);
    step(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
    idle(14, 1'b0);

    // count view from zero
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    idle(1, 1'b1);
    for (int i = 0; i < 300; i++) step(1'b1, 8'($urandom), 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);

    // saturation: preload the counter to all-F
    @(posedge clk);
    #2;
    force dut.byte_cnt_q = 32'hFFFF_FFFF;
    m_cnt = 64'hFFFF_FFFF;
    step(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    release dut.byte_cnt_q;
    step(1'b1, 8'hBB, 1'b0, 1'b1, 1'b0);
    idle(1, 1'b1);

    // framing error then clear colliding with a byte
    step(1'b1, 8'hCC, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b0);
    step(1'b1, 8'hDD, 1'b0, 1'b0, 1'b1);
    idle(3, 1'b0);

    // asynchronous reset while activity is running
    step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rx_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_value", value, 32'h0);
    check("async_rst_point", 32'(point), 32'hFF);
    check("async_rst_mask", 32'(mask_n), 32'hFF);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);

    for (int i = 0; i < 2000; i++) begin
      step(($urandom % 3) == 0, 8'($urandom), ($urandom % 8) == 0,
           ((i / 40) % 2) == 1, ($urandom % 60) == 0);
    end
    idle(12, 1'b0);

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
